// File: rtl/move_scan_ctrl.sv
// move_scan_ctrl
//  Sequences the per-direction legality walk for one Reversi move. A start
//  request in idle snapshots the target, colour and board. The target is then
//  checked for emptiness, and the eight directions are walked one cell per
//  clock. The walk accumulates the capturing directions and the flip mask.
//
// Parameters
//  FLIP_EN       1: walk all 8 directions and build flip_mask.
//                0: legality only; stop at the first capture, flip_mask stays 0.
// Ports
//  clk           in   1    system clock, rising edge
//  resetn        in   1    asynchronous active-low reset
//  start         in   1    scan request, sampled only in idle
//  x, y          in   3    target column / row
//  player_black  in   1    1 = black to move, 0 = white
//  board         in   128  cell (x,y) at bits [2*(8y+x)+1 : 2*(8y+x)]; 11 black, 10 white, 0? empty
//  busy          out  1    high from the capture edge until done
//  done          out  1    one-cycle pulse, results valid from this cycle
//  valid         out  1    move legal (at least one capturing direction)
//  dir_mask      out  8    bit d set = direction d captures
//  flip_mask     out  64   bit 8y+x set = disc at (x,y) flips
module move_scan_ctrl #(
  parameter int unsigned FLIP_EN = 1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic [2:0]   x,
  input  logic [2:0]   y,
  input  logic         player_black,
  input  logic [127:0] board,
  output logic         busy,
  output logic         done,
  output logic         valid,
  output logic [7:0]   dir_mask,
  output logic [63:0]  flip_mask
);

  typedef enum logic [1:0] {StIdle, StCheck, StWalk, StDone} state_e;

  state_e              state;
  logic [2:0]          tx, ty;
  logic                blk;
  logic [127:0]        brd;
  logic [2:0]          dir;
  logic signed [3:0]   cx, cy;
  logic [2:0]          run_cnt;
  logic [63:0]         run_mask;

  // Direction table: 0 N, 1 S, 2 W, 3 E, 4 NW, 5 SW, 6 NE, 7 SE.
  function automatic logic signed [3:0] step_x(input logic [2:0] d);
    logic signed [3:0] s;
    case (d)
      3'd2, 3'd4, 3'd5: s = -4'sd1;
      3'd3, 3'd6, 3'd7: s = 4'sd1;
      default:          s = 4'sd0;
    endcase
    return s;
  endfunction

  function automatic logic signed [3:0] step_y(input logic [2:0] d);
    logic signed [3:0] s;
    case (d)
      3'd0, 3'd4, 3'd6: s = -4'sd1;
      3'd1, 3'd5, 3'd7: s = 4'sd1;
      default:          s = 4'sd0;
    endcase
    return s;
  endfunction

  // Cursor cell decode. The cursor only ever lies in -1..8, so bit 3 alone
  // flags off-board; the low bits are never used as a wrapped index.
  logic              off_board;
  logic [5:0]        cur_idx;
  logic [1:0]        cur_cell;
  logic [1:0]        tgt_cell;
  logic              cell_empty, cell_own, cell_opp;
  logic [2:0]        dir_nx;
  logic signed [3:0] tx_s, ty_s;

  always_comb begin
    off_board  = cx[3] | cy[3];
    cur_idx    = {cy[2:0], cx[2:0]};
    cur_cell   = brd[{cur_idx, 1'b0} +: 2];
    tgt_cell   = brd[{ty, tx, 1'b0} +: 2];
    cell_empty = ~cur_cell[1];
    cell_own   = (cur_cell == {1'b1, blk});
    cell_opp   = (cur_cell == {1'b1, ~blk});
    dir_nx     = dir + 3'd1;
    tx_s       = $signed({1'b0, tx});
    ty_s       = $signed({1'b0, ty});
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= StIdle;
      tx        <= '0;
      ty        <= '0;
      blk       <= 1'b0;
      brd       <= '0;
      dir       <= '0;
      cx        <= '0;
      cy        <= '0;
      run_cnt   <= '0;
      run_mask  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      valid     <= 1'b0;
      dir_mask  <= '0;
      flip_mask <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            tx        <= x;
            ty        <= y;
            blk       <= player_black;
            brd       <= board;
            busy      <= 1'b1;
            valid     <= 1'b0;
            dir_mask  <= '0;
            flip_mask <= '0;
            state     <= StCheck;
          end
        end

        StCheck: begin
          if (tgt_cell[1]) begin
            state <= StDone;
          end else begin
            dir      <= 3'd0;
            cx       <= tx_s + step_x(3'd0);
            cy       <= ty_s + step_y(3'd0);
            run_cnt  <= '0;
            run_mask <= '0;
            state    <= StWalk;
          end
        end

        StWalk: begin
          if (!off_board && cell_opp) begin
            // Extend the run of opposite discs and keep walking.
            run_mask[cur_idx] <= 1'b1;
            run_cnt           <= run_cnt + 3'd1;
            cx                <= cx + step_x(dir);
            cy                <= cy + step_y(dir);
          end else begin
            // Direction ends here: capture if bracketed by an own disc.
            logic captured;
            captured = !off_board && !cell_empty && cell_own && (run_cnt != 3'd0);
            if (captured) begin
              dir_mask[dir] <= 1'b1;
              if (FLIP_EN != 0) flip_mask <= flip_mask | run_mask;
            end
            run_mask <= '0;
            run_cnt  <= '0;
            if ((dir == 3'd7) || (captured && (FLIP_EN == 0))) begin
              state <= StDone;
            end else begin
              dir <= dir_nx;
              cx  <= tx_s + step_x(dir_nx);
              cy  <= ty_s + step_y(dir_nx);
            end
          end
        end

        StDone: begin
          done  <= 1'b1;
          valid <= |dir_mask;
          busy  <= 1'b0;
          state <= StIdle;
        end

        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_move_scan_ctrl.sv
module tb_move_scan_ctrl;

  localparam logic [1:0] BLK = 2'b11;
  localparam logic [1:0] WHT = 2'b10;

  logic         clk = 1'b0;
  logic         resetn;
  logic         start_a, start_b;
  logic [2:0]   x, y;
  logic         player_black;
  logic [127:0] board;

  logic         busy_a, done_a, valid_a;
  logic [7:0]   dir_a;
  logic [63:0]  flip_a;
  logic         busy_b, done_b, valid_b;
  logic [7:0]   dir_b;
  logic [63:0]  flip_b;

  always #5 clk = ~clk;

  move_scan_ctrl #(.FLIP_EN(1)) u_dut (
    .clk(clk), .resetn(resetn), .start(start_a), .x(x), .y(y),
    .player_black(player_black), .board(board),
    .busy(busy_a), .done(done_a), .valid(valid_a), .dir_mask(dir_a), .flip_mask(flip_a)
  );

  move_scan_ctrl #(.FLIP_EN(0)) u_dut_legal (
    .clk(clk), .resetn(resetn), .start(start_b), .x(x), .y(y),
    .player_black(player_black), .board(board),
    .busy(busy_b), .done(done_b), .valid(valid_b), .dir_mask(dir_b), .flip_mask(flip_b)
  );

  // Observed outputs of whichever instance the current step targets.
  bit          cur_sel = 1'b0;
  logic        busy_s, done_s, valid_s;
  logic [7:0]  dir_s;
  logic [63:0] flip_s;
  assign busy_s  = cur_sel ? busy_b  : busy_a;
  assign done_s  = cur_sel ? done_b  : done_a;
  assign valid_s = cur_sel ? valid_b : valid_a;
  assign dir_s   = cur_sel ? dir_b   : dir_a;
  assign flip_s  = cur_sel ? flip_b  : flip_a;

  typedef struct {
    int          lat;
    logic        v;
    logic [7:0]  dm;
    logic [63:0] fm;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] put(input logic [127:0] b, input int cx, input int cy,
                                       input logic [1:0] v);
    logic [127:0] r;
    r = b;
    r[2*(8*cy+cx) +: 2] = v;
    return r;
  endfunction

  // Issue one scan, push its expectation, wait (bounded) for done and compare.
  // With disturb set, a second start plus junk inputs are driven mid-scan.
  task automatic scan(input string tag, input bit sel, input int tx, input int ty,
                      input logic pb, input logic [127:0] b, input int lat,
                      input logic v, input logic [7:0] dm, input logic [63:0] fm,
                      input bit disturb);
    exp_t e, got;
    int   n;
    bit   seen;
    e.lat = lat; e.v = v; e.dm = dm; e.fm = fm;
    sb.push_back(e);
    cur_sel = sel;
    @(negedge clk);
    x = tx[2:0]; y = ty[2:0]; player_black = pb; board = b;
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0; start_b = 1'b0;
    chk({tag, "_busy_on_capture"}, {63'd0, busy_s}, 64'd1);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 80) begin
      @(posedge clk);
      #1;
      n++;
      if (done_s) seen = 1'b1;
      if (disturb && n == 1) begin
        x = 3'd3; y = 3'd3; player_black = ~pb; board = '0;
        if (sel) start_b = 1'b1; else start_a = 1'b1;
      end
      if (disturb && n == 2) begin
        start_a = 1'b0; start_b = 1'b0;
      end
    end
    got = sb.pop_front();
    if (!seen) begin
      chk({tag, "_done_timeout"}, 64'd0, 64'd1);
    end else begin
      chk({tag, "_latency"}, 64'(n), 64'(got.lat));
      chk({tag, "_valid"}, {63'd0, valid_s}, {63'd0, got.v});
      chk({tag, "_dir_mask"}, {56'd0, dir_s}, {56'd0, got.dm});
      chk({tag, "_flip_mask"}, flip_s, got.fm);
      chk({tag, "_busy_at_done"}, {63'd0, busy_s}, 64'd0);
      @(posedge clk);
      #1;
      chk({tag, "_done_one_cycle"}, {63'd0, done_s}, 64'd0);
      chk({tag, "_dir_mask_held"}, {56'd0, dir_s}, {56'd0, got.dm});
    end
  endtask

  logic [127:0] opening, diag, le_board;
  int           extra;

  initial begin
    resetn = 1'b0;
    start_a = 1'b0; start_b = 1'b0;
    x = '0; y = '0; player_black = 1'b1; board = '0;

    opening = '0;
    opening = put(opening, 3, 3, WHT);
    opening = put(opening, 4, 4, WHT);
    opening = put(opening, 4, 3, BLK);
    opening = put(opening, 3, 4, BLK);

    diag = put(128'd0, 7, 7, BLK);
    for (int i = 1; i <= 6; i++) diag = put(diag, i, i, WHT);

    le_board = put(opening, 0, 3, BLK);
    le_board = put(le_board, 1, 3, WHT);

    #12;
    chk("reset_busy", {63'd0, busy_a}, 64'd0);
    chk("reset_done", {63'd0, done_a}, 64'd0);
    chk("reset_valid", {63'd0, valid_a}, 64'd0);
    chk("reset_dir_mask", {56'd0, dir_a}, 64'd0);
    chk("reset_flip_mask", flip_a, 64'd0);
    chk("reset_busy_legal", {63'd0, busy_b}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    scan("open_black", 1'b0, 2, 3, 1'b1, opening, 11, 1'b1, 8'h08, 64'd1 << 27, 1'b0);
    scan("occupied", 1'b0, 3, 3, 1'b1, opening, 2, 1'b0, 8'h00, 64'd0, 1'b0);
    scan("empty_corner", 1'b0, 0, 0, 1'b1, 128'd0, 10, 1'b0, 8'h00, 64'd0, 1'b0);
    scan("diag_run", 1'b0, 0, 0, 1'b1, diag, 16, 1'b1, 8'h80,
         (64'd1 << 9) | (64'd1 << 18) | (64'd1 << 27) | (64'd1 << 36) |
         (64'd1 << 45) | (64'd1 << 54), 1'b0);
    scan("open_white", 1'b0, 4, 2, 1'b0, opening, 11, 1'b1, 8'h02, 64'd1 << 28, 1'b0);
    scan("legal_only", 1'b1, 2, 3, 1'b1, le_board, 6, 1'b1, 8'h04, 64'd0, 1'b0);

    // Abort a scan with reset after direction 3 has already captured.
    cur_sel = 1'b0;
    @(negedge clk);
    x = 3'd2; y = 3'd3; player_black = 1'b1; board = opening; start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("mid_scan_dir_mask", {56'd0, dir_a}, 64'h08);
    resetn = 1'b0;
    #1;
    chk("abort_busy", {63'd0, busy_a}, 64'd0);
    chk("abort_done", {63'd0, done_a}, 64'd0);
    chk("abort_valid", {63'd0, valid_a}, 64'd0);
    chk("abort_dir_mask", {56'd0, dir_a}, 64'd0);
    chk("abort_flip_mask", flip_a, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    extra = 0;
    repeat (60) begin
      @(posedge clk);
      #1;
      if (done_a || busy_a) extra++;
    end
    chk("abort_no_done", 64'(extra), 64'd0);

    scan("start_while_busy", 1'b0, 0, 0, 1'b1, diag, 16, 1'b1, 8'h80,
         (64'd1 << 9) | (64'd1 << 18) | (64'd1 << 27) | (64'd1 << 36) |
         (64'd1 << 45) | (64'd1 << 54), 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
